// File: rtl/l2_fill_ctrl.sv
// rtl/l2_fill_ctrl.sv - L2 line-fill controller with optional victim write-back
//
// Purpose:
//   Services an L1 miss by fetching one 16-byte line from memory as a burst of
//   BURST_LENGTH beats. When the build defines L2_WRITEBACK_EN, a dirty victim
//   line is first written back to memory. Without the macro the L2 is
//   write-through: the write-back inputs are ignored, and mem_we and mem_wdata
//   stay 0.
//
// Ports:
//   clk, rst_n          sole clock; asynchronous active-low reset
//   miss_req, miss_addr line-fill request (level) and missing byte address
//   wb_req, wb_addr     victim dirty flag and victim address (sampled with miss_req)
//   wb_data             victim beat selected by beat_idx
//   stall               holds the L1 off while the fill is in flight
//   done                one-cycle completion pulse
//   fill_we, fill_data  beat write into the cache array
//   beat_idx            current beat number inside a burst
//   mem_req/we/addr     memory command, held until mem_ack
//   mem_wdata           write-back beat data
//   mem_ack             command accept
//   mem_stb, mem_rdata  beat strobe and read data
//
// Configuration macro: L2_WRITEBACK_EN

module l2_fill_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH_L2 = 64,
  parameter int BURST_LENGTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_req,
  input  logic [ADDR_WIDTH-1:0]    miss_addr,
  input  logic                     wb_req,
  input  logic [ADDR_WIDTH-1:0]    wb_addr,
  input  logic [DATA_WIDTH_L2-1:0] wb_data,
  output logic                     stall,
  output logic                     done,
  output logic                     fill_we,
  output logic [DATA_WIDTH_L2-1:0] fill_data,
  output logic [1:0]               beat_idx,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH_L2-1:0] mem_wdata,
  input  logic                     mem_ack,
  input  logic                     mem_stb,
  input  logic [DATA_WIDTH_L2-1:0] mem_rdata
);

  localparam logic [1:0] LAST_BEAT = 2'(BURST_LENGTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_WB_BURST,
    ST_RD_REQ,
    ST_RD_BURST,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_beat;
  logic [1:0]            w_beat_nxt;
  logic                  w_capture;
  logic [ADDR_WIDTH-1:0] r_miss_addr;
  logic [ADDR_WIDTH-1:0] w_miss_line;
  logic                  w_unused_bits;

  // Lines are 16 bytes, so the offset bits never reach memory.
  assign w_miss_line = {miss_addr[ADDR_WIDTH-1:4], 4'b0000};

`ifdef L2_WRITEBACK_EN
  logic [ADDR_WIDTH-1:0] r_wb_addr;
  logic [ADDR_WIDTH-1:0] w_wb_line;

  assign w_wb_line     = {wb_addr[ADDR_WIDTH-1:4], 4'b0000};
  assign w_unused_bits = ^{miss_addr[3:0], wb_addr[3:0]};
`else
  assign w_unused_bits = ^{miss_addr[3:0], wb_req, wb_addr, wb_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_beat      <= 2'd0;
      r_miss_addr <= '0;
`ifdef L2_WRITEBACK_EN
      r_wb_addr   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      if (w_capture) begin
        r_miss_addr <= w_miss_line;
`ifdef L2_WRITEBACK_EN
        r_wb_addr   <= w_wb_line;
`endif
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_capture   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_we     = 1'b0;
    fill_data   = '0;
    done        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (miss_req) begin
          w_capture  = 1'b1;
          w_beat_nxt = 2'd0;
`ifdef L2_WRITEBACK_EN
          w_state_nxt = wb_req ? ST_WB_REQ : ST_RD_REQ;
`else
          w_state_nxt = ST_RD_REQ;
`endif
        end
      end

`ifdef L2_WRITEBACK_EN
      ST_WB_REQ: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = r_wb_addr;
        if (mem_ack) begin
          w_state_nxt = ST_WB_BURST;
          w_beat_nxt  = 2'd0;
        end
      end

      ST_WB_BURST: begin
        mem_wdata = wb_data;
        if (mem_stb) begin
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = ST_RD_REQ;
            w_beat_nxt  = 2'd0;
          end else begin
            w_beat_nxt = r_beat + 2'd1;
          end
        end
      end
`endif

      ST_RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = r_miss_addr;
        if (mem_ack) begin
          w_state_nxt = ST_RD_BURST;
          w_beat_nxt  = 2'd0;
        end
      end

      ST_RD_BURST: begin
        // Beats go straight through to the array in the strobe cycle.
        if (mem_stb) begin
          fill_we   = 1'b1;
          fill_data = mem_rdata;
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = ST_DONE;
            w_beat_nxt  = 2'd0;
          end else begin
            w_beat_nxt = r_beat + 2'd1;
          end
        end
      end

      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_beat_nxt  = 2'd0;
      end
    endcase
  end

  // Stall is gated by rst_n so that every output reads 0 during reset,
  // even while the requester keeps miss_req high.
  assign stall = rst_n &&
                 (((r_state != ST_IDLE) && (r_state != ST_DONE)) ||
                  ((r_state == ST_IDLE) && miss_req));

  assign beat_idx = r_beat;

endmodule

// File: tb/tb_l2_fill_ctrl.sv
// tb/tb_l2_fill_ctrl.sv - directed self-checking bench for l2_fill_ctrl

module tb_l2_fill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic [63:0] wb_data;
  logic        stall;
  logic        done;
  logic        fill_we;
  logic [63:0] fill_data;
  logic [1:0]  beat_idx;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic        mem_stb;
  logic [63:0] mem_rdata;

  int checks;
  int errors;

  l2_fill_ctrl #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH_L2(64),
    .BURST_LENGTH (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .miss_req (miss_req),
    .miss_addr(miss_addr),
    .wb_req   (wb_req),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .stall    (stall),
    .done     (done),
    .fill_we  (fill_we),
    .fill_data(fill_data),
    .beat_idx (beat_idx),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_stb  (mem_stb),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled 1 time unit later, well clear of both clock edges.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"}, {63'd0, mem_req}, 64'd0);
    chk({tag, "_fill_we"}, {63'd0, fill_we}, 64'd0);
    chk({tag, "_done"},    {63'd0, done},    64'd0);
    chk({tag, "_stall"},   {63'd0, stall},   64'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    miss_req  = 1'b0;
    miss_addr = 32'h0;
    wb_req    = 1'b0;
    wb_addr   = 32'h0;
    wb_data   = 64'h0;
    mem_ack   = 1'b0;
    mem_stb   = 1'b0;
    mem_rdata = 64'h0;

    // Reset state
    step(); step();
    settle();
    chk_quiet("rst");
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_beat_idx", {62'd0, beat_idx}, 64'd0);
    chk("rst_mem_we",   {63'd0, mem_we},   64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Clean miss, immediate ack/strobe (strobe in IDLE/RD_REQ is ignored)
    miss_req = 1'b1; miss_addr = 32'h0000_1234; mem_ack = 1'b1; mem_stb = 1'b1;
    settle();
    chk("c_idle_stall",   {63'd0, stall},   64'd1);
    chk("c_idle_mem_req", {63'd0, mem_req}, 64'd0);
    step();
    settle();
    chk("c_rq_mem_req",  {63'd0, mem_req},  64'd1);
    chk("c_rq_mem_we",   {63'd0, mem_we},   64'd0);
    chk("c_rq_mem_addr", {32'd0, mem_addr}, 64'h0000_1230);
    chk("c_rq_fill_we",  {63'd0, fill_we},  64'd0);
    step();
    mem_ack = 1'b0; mem_rdata = 64'h1111_2222_3333_4444;
    settle();
    chk("c_b0_fill_we",   {63'd0, fill_we},  64'd1);
    chk("c_b0_fill_data", fill_data,         64'h1111_2222_3333_4444);
    chk("c_b0_beat_idx",  {62'd0, beat_idx}, 64'd0);
    chk("c_b0_mem_req",   {63'd0, mem_req},  64'd0);
    step();
    mem_rdata = 64'h5555_6666_7777_8888;
    settle();
    chk("c_b1_fill_we",   {63'd0, fill_we},  64'd1);
    chk("c_b1_fill_data", fill_data,         64'h5555_6666_7777_8888);
    chk("c_b1_beat_idx",  {62'd0, beat_idx}, 64'd1);
    step();
    miss_req = 1'b0; mem_stb = 1'b0; mem_rdata = 64'h0;
    settle();
    chk("c_done_pulse", {63'd0, done},    64'd1);
    chk("c_done_stall", {63'd0, stall},   64'd0);
    chk("c_done_fill",  {63'd0, fill_we}, 64'd0);
    step();
    settle();
    chk_quiet("c_after");

    // Delayed ack (5 cycles) and gapped strobes 1,0,0,1
    step();
    miss_req = 1'b1; miss_addr = 32'h0000_2F0F;
    settle();
    for (int i = 0; i < 6; i++) begin
      step();
      mem_ack = (i == 5);
      settle();
      chk("d_req_held", {63'd0, mem_req},  64'd1);
      chk("d_req_addr", {32'd0, mem_addr}, 64'h0000_2F00);
    end
    step();
    mem_ack = 1'b0; mem_stb = 1'b1; mem_rdata = 64'hA0A0_A0A0_A0A0_A0A0;
    settle();
    chk("d_s1_fill_we",  {63'd0, fill_we},  64'd1);
    chk("d_s1_beat_idx", {62'd0, beat_idx}, 64'd0);
    chk("d_s1_mem_req",  {63'd0, mem_req},  64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      mem_stb = 1'b0; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      settle();
      chk("d_gap_fill_we",  {63'd0, fill_we},  64'd0);
      chk("d_gap_fill_data", fill_data,        64'd0);
      chk("d_gap_beat_idx", {62'd0, beat_idx}, 64'd1);
    end
    step();
    mem_stb = 1'b1; mem_rdata = 64'hB1B1_B1B1_B1B1_B1B1;
    settle();
    chk("d_s2_fill_we",   {63'd0, fill_we},  64'd1);
    chk("d_s2_fill_data", fill_data,         64'hB1B1_B1B1_B1B1_B1B1);
    chk("d_s2_beat_idx",  {62'd0, beat_idx}, 64'd1);
    step();
    miss_req = 1'b0; mem_stb = 1'b0;
    settle();
    chk("d_done", {63'd0, done}, 64'd1);
    step();

    // Reset after the first read beat
    miss_req = 1'b1; miss_addr = 32'h0000_4444; mem_ack = 1'b1;
    step();
    settle();
    chk("r_rq_mem_req", {63'd0, mem_req}, 64'd1);
    step();
    mem_ack = 1'b0; mem_stb = 1'b1; mem_rdata = 64'hC3C3_C3C3_C3C3_C3C3;
    settle();
    chk("r_b0_fill_we", {63'd0, fill_we}, 64'd1);
    step();
    mem_ack = 1'b1;
    rst_n = 1'b0;
    settle();
    chk_quiet("r_inrst");
    chk("r_inrst_beat", {62'd0, beat_idx}, 64'd0);
    chk("r_inrst_addr", {32'd0, mem_addr}, 64'd0);
    step();
    miss_req = 1'b0; mem_ack = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      mem_ack = 1'b1;
      settle();
      chk_quiet("r_post");
    end
    mem_ack = 1'b0; mem_stb = 1'b0;

    // Back-to-back misses: stall low only in the DONE cycle
    step();
    miss_req = 1'b1; miss_addr = 32'h0000_5000; mem_ack = 1'b1; mem_stb = 1'b1;
    mem_rdata = 64'h0101_0101_0101_0101;
    step(); step(); step();
    settle();
    chk("bb_b1_fill", {63'd0, fill_we}, 64'd1);
    step();
    miss_req = 1'b0;
    settle();
    chk("bb_done",       {63'd0, done},  64'd1);
    chk("bb_done_stall", {63'd0, stall}, 64'd0);
    step();
    miss_req = 1'b1; miss_addr = 32'h0000_6008;
    settle();
    chk("bb_idle_stall", {63'd0, stall}, 64'd1);
    chk("bb_idle_done",  {63'd0, done},  64'd0);
    step();
    settle();
    chk("bb2_mem_req",  {63'd0, mem_req},  64'd1);
    chk("bb2_mem_addr", {32'd0, mem_addr}, 64'h0000_6000);
    step(); step();
    step();
    miss_req = 1'b0; mem_stb = 1'b0; mem_ack = 1'b0;
    settle();
    chk("bb2_done", {63'd0, done}, 64'd1);
    step();

    // Dirty miss
    miss_req = 1'b1; miss_addr = 32'h0000_7777; wb_req = 1'b1; wb_addr = 32'h0000_ABCC;
    mem_ack = 1'b1; mem_stb = 1'b1;
`ifdef L2_WRITEBACK_EN
    step();
    settle();
    chk("w_wr_mem_req",  {63'd0, mem_req},  64'd1);
    chk("w_wr_mem_we",   {63'd0, mem_we},   64'd1);
    chk("w_wr_mem_addr", {32'd0, mem_addr}, 64'h0000_ABC0);
    for (int n = 0; n < 2; n++) begin
      step();
      wb_data = 64'hDEAD_BEEF_0000_0000 | 64'(n);
      settle();
      chk("w_beat_idx",  {62'd0, beat_idx}, 64'(n));
      chk("w_mem_wdata", mem_wdata,         64'hDEAD_BEEF_0000_0000 | 64'(n));
      chk("w_beat_req",  {63'd0, mem_req},  64'd0);
      chk("w_beat_fill", {63'd0, fill_we},  64'd0);
    end
    wb_data = 64'h0;
`endif
    step();
    settle();
    chk("w_rd_mem_req",  {63'd0, mem_req},  64'd1);
    chk("w_rd_mem_we",   {63'd0, mem_we},   64'd0);
    chk("w_rd_mem_addr", {32'd0, mem_addr}, 64'h0000_7770);
    for (int n = 0; n < 2; n++) begin
      step();
      wb_data   = 64'h1234_5678_9ABC_DEF0;
      mem_rdata = 64'hE000_0000_0000_0000 | 64'(n);
      settle();
      chk("w_fill_we",   {63'd0, fill_we},  64'd1);
      chk("w_fill_data", fill_data,         64'hE000_0000_0000_0000 | 64'(n));
      chk("w_rd_we",     {63'd0, mem_we},   64'd0);
      chk("w_rd_wdata",  mem_wdata,         64'd0);
    end
    step();
    miss_req = 1'b0; wb_req = 1'b0; mem_ack = 1'b0; mem_stb = 1'b0;
    settle();
    chk("w_done", {63'd0, done}, 64'd1);
    step();
    settle();
    chk("w_done_once", {63'd0, done}, 64'd0);
    chk_quiet("w_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
